// File: rtl/pwm_dt_sched_pkg.sv
// rtl/pwm_dt_sched_pkg.sv - shared types, default widths and config sanitiser for pwm_dt_sched
package pwm_dt_sched_pkg;

  localparam int PWM_CNT_W      = 16;
  localparam int PWM_DT_W       = 8;
  localparam int PWM_MIN_PERIOD = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_SHUT = 2'd2
  } state_t;

  typedef struct packed {
    logic [PWM_CNT_W-1:0] period;
    logic [PWM_CNT_W-1:0] duty;
    logic [PWM_DT_W-1:0]  dead;
  } cfg_t;

  // Duty is clamped against the already-clamped period, so {1,4} becomes {2,2}.
  function automatic cfg_t sanitise(input cfg_t c, input logic [PWM_CNT_W-1:0] min_period);
    cfg_t s;
    s = c;
    if (s.period < min_period) s.period = min_period;
    if (s.duty > s.period) s.duty = s.period;
    return s;
  endfunction

endpackage

// File: rtl/pwm_dt_sched_dead_time_gen.sv
// rtl/pwm_dt_sched_dead_time_gen.sv - complementary gate pair with dead time inserted on every raw edge
module pwm_dt_sched_dead_time_gen #(
  parameter int DT_W = 8
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            force_low_i,
  input  logic            raw_i,
  input  logic [DT_W-1:0] dead_i,
  output logic            hi_o,
  output logic            lo_o
);

  localparam logic [DT_W-1:0] DT_ONE = DT_W'(1);

  logic            prev_q, prev_d;
  logic [DT_W-1:0] cnt_q, cnt_d;
  logic            hi_q, hi_d;
  logic            lo_q, lo_d;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      prev_q <= 1'b0;
      cnt_q  <= '0;
      hi_q   <= 1'b0;
      lo_q   <= 1'b0;
    end else begin
      prev_q <= prev_d;
      cnt_q  <= cnt_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
    end
  end

  // While forced low the counter is held at the dead time, so leaving force
  // still waits out a full dead time before the first side turns on.
  always_comb begin
    prev_d = prev_q;
    cnt_d  = cnt_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    if (force_low_i) begin
      prev_d = 1'b0;
      cnt_d  = dead_i;
      hi_d   = 1'b0;
      lo_d   = 1'b0;
    end else if (raw_i != prev_q) begin
      prev_d = raw_i;
      cnt_d  = dead_i;
      if (dead_i == '0) begin
        hi_d = raw_i;
        lo_d = !raw_i;
      end else begin
        hi_d = 1'b0;
        lo_d = 1'b0;
      end
    end else if (cnt_q > DT_ONE) begin
      cnt_d = cnt_q - DT_ONE;
    end else begin
      cnt_d = '0;
      hi_d  = raw_i;
      lo_d  = !raw_i;
    end
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;

endmodule

// File: rtl/pwm_dt_sched.sv
// rtl/pwm_dt_sched.sv - PWM scheduler with shadowed config, dead-time gate split and shutdown sequencing
module pwm_dt_sched
  import pwm_dt_sched_pkg::*;
#(
  parameter int CNT_W      = PWM_CNT_W,
  parameter int DT_W       = PWM_DT_W,
  parameter int MIN_PERIOD = PWM_MIN_PERIOD
) (
  input  logic             emu_clk,
  input  logic             emu_rst_n,
  input  logic             enable,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_duty,
  input  logic [DT_W-1:0]  cfg_dead,
  output logic             hi_gate,
  output logic             lo_gate,
  output logic             period_start,
  output logic             busy
);

  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [DT_W-1:0]  DT_ONE    = DT_W'(1);
  localparam cfg_t             RESET_CFG = '{period: PWM_CNT_W'(MIN_PERIOD), duty: '0, dead: '0};

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DT_W-1:0]  shut_q, shut_d;
  cfg_t             act_q, act_d;
  cfg_t             pend_q, pend_d;
  logic             pend_full_q, pend_full_d;
  logic             raw_q, raw_d;
  logic             ps_q, ps_d;

  logic             wrap;
  logic             cfg_xfer;
  logic             load_act;
  logic             force_low;

  always_ff @(posedge emu_clk) begin
    if (!emu_rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      shut_q      <= '0;
      act_q       <= RESET_CFG;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      raw_q       <= 1'b0;
      ps_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shut_q      <= shut_d;
      act_q       <= act_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      raw_q       <= raw_d;
      ps_q        <= ps_d;
    end
  end

  assign wrap      = (state_q == ST_RUN) && (cnt_q == (act_q.period - CNT_ONE));
  assign cfg_ready = !pend_full_q;
  assign cfg_xfer  = cfg_valid && cfg_ready;
  assign load_act  = pend_full_q && ((state_q == ST_IDLE) || wrap);

  // A write landing on the wrap edge finds pending empty, so it waits for the next wrap.
  always_comb begin
    act_d       = act_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    if (load_act) begin
      act_d       = sanitise(pend_q, PWM_CNT_W'(MIN_PERIOD));
      pend_full_d = 1'b0;
    end
    if (cfg_xfer) begin
      pend_d      = '{period: cfg_period, duty: cfg_duty, dead: cfg_dead};
      pend_full_d = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shut_d  = shut_q;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (enable) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!enable) begin
          cnt_d = '0;
          if (act_q.dead == '0) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_SHUT;
            shut_d  = act_q.dead;
          end
        end else if (wrap) begin
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_SHUT: begin
        if (shut_q <= DT_ONE) begin
          state_d = ST_IDLE;
          shut_d  = '0;
        end else begin
          shut_d = shut_q - DT_ONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign raw_d     = (state_q == ST_RUN) && (cnt_q < act_q.duty);
  assign ps_d      = (state_q == ST_RUN) && (cnt_q == '0);
  // Keyed off the next state so both gates drop on the very edge that leaves RUN.
  assign force_low = (state_d != ST_RUN);

  pwm_dt_sched_dead_time_gen #(
    .DT_W(DT_W)
  ) u_dt (
    .clk_i      (emu_clk),
    .rst_ni     (emu_rst_n),
    .force_low_i(force_low),
    .raw_i      (raw_q),
    .dead_i     (act_q.dead),
    .hi_o       (hi_gate),
    .lo_o       (lo_gate)
  );

  assign period_start = ps_q;
  assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_pwm_dt_sched.sv
// tb/tb_pwm_dt_sched.sv - scoreboard bench: per-period gate counts plus directed handshake/shutdown/reset checks
module tb_pwm_dt_sched;

  logic        emu_clk = 1'b0;
  logic        emu_rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        cfg_valid = 1'b0;
  logic [15:0] cfg_period = '0;
  logic [15:0] cfg_duty = '0;
  logic [7:0]  cfg_dead = '0;
  logic        cfg_ready, hi_gate, lo_gate, period_start, busy;

  typedef struct {
    int len;
    int hi;
    int lo;
  } win_t;

  win_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 emu_clk = ~emu_clk;

  pwm_dt_sched dut (
    .emu_clk     (emu_clk),
    .emu_rst_n   (emu_rst_n),
    .enable      (enable),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_period  (cfg_period),
    .cfg_duty    (cfg_duty),
    .cfg_dead    (cfg_dead),
    .hi_gate     (hi_gate),
    .lo_gate     (lo_gate),
    .period_start(period_start),
    .busy        (busy)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic push_win(input int n, input int len, input int hi, input int lo);
    win_t w;
    w.len = len;
    w.hi  = hi;
    w.lo  = lo;
    repeat (n) exp_q.push_back(w);
  endtask

  task automatic wait_ps(input int n);
    for (int k = 0; k < n; k++) begin
      int t;
      t = 0;
      do begin
        @(negedge emu_clk);
        t++;
      end while (!period_start && t < 200);
      if (!period_start) begin
        n_checks++;
        n_fail++;
        $display("FAIL wait_ps: no period_start within 200 cycles at %0t", $time);
      end
    end
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    do begin
      @(negedge emu_clk);
      t++;
    end while (busy && t < 100);
    check("reach_idle", busy, 0);
  endtask

  task automatic send_cfg(input int p, input int d, input int dt);
    int t;
    t = 0;
    cfg_period = 16'(p);
    cfg_duty   = 16'(d);
    cfg_dead   = 8'(dt);
    cfg_valid  = 1'b1;
    do begin
      @(negedge emu_clk);
      t++;
    end while (!cfg_ready && t < 50);
    check("cfg_ready_for_send", cfg_ready, 1);
    @(posedge emu_clk);
    #1 cfg_valid = 1'b0;
  endtask

  // Monitor: each period_start closes a window of gate activity and scores it.
  initial begin : monitor
    int   len, hc, lc, bc;
    bit   in_win;
    win_t w;
    in_win = 1'b0;
    len = 0; hc = 0; lc = 0; bc = 0;
    forever begin
      @(negedge emu_clk);
      if (!emu_rst_n || !busy) begin
        in_win = 1'b0;
      end else begin
        if (period_start) begin
          if (in_win && exp_q.size() > 0) begin
            w = exp_q.pop_front();
            check("win_len", len, w.len);
            check("win_hi_cycles", hc, w.hi);
            check("win_lo_cycles", lc, w.lo);
            check("win_both_high", bc, 0);
          end
          in_win = 1'b1;
          len = 0; hc = 0; lc = 0; bc = 0;
        end
        if (in_win) begin
          len++;
          if (hi_gate) hc++;
          if (lo_gate) lc++;
          if (hi_gate && lo_gate) bc++;
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    repeat (3) @(posedge emu_clk);
    #1;
    check("rst_hi", hi_gate, 0);
    check("rst_lo", lo_gate, 0);
    check("rst_ps", period_start, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", cfg_ready, 1);
    emu_rst_n = 1'b1;

    // 50% duty, no dead time; first period_start one cycle after RUN entry
    send_cfg(10, 5, 0);
    @(posedge emu_clk);
    #1 enable = 1'b1;
    @(posedge emu_clk);
    #1;
    check("entry_ps_low", period_start, 0);
    check("entry_busy", busy, 1);
    @(posedge emu_clk);
    #1;
    check("first_ps", period_start, 1);
    @(posedge emu_clk);
    push_win(2, 10, 5, 5);

    // shadowed update written at cnt=3 takes effect at the next wrap
    wait_ps(2);
    @(posedge emu_clk);
    push_win(1, 10, 5, 5);
    push_win(2, 20, 15, 5);
    @(posedge emu_clk);
    #1;
    cfg_period = 16'd20;
    cfg_duty   = 16'd15;
    cfg_dead   = 8'd0;
    cfg_valid  = 1'b1;
    @(posedge emu_clk);
    #1 cfg_valid = 1'b0;
    check("ready_low_after_xfer", cfg_ready, 0);
    repeat (5) @(posedge emu_clk);
    #1;
    check("ready_low_before_wrap", cfg_ready, 0);
    wait_ps(1);
    check("ready_high_after_wrap", cfg_ready, 1);
    wait_ps(2);

    // reset during RUN with a pending config
    send_cfg(10, 5, 2);
    check("pending_held", cfg_ready, 0);
    emu_rst_n = 1'b0;
    enable    = 1'b0;
    @(posedge emu_clk);
    #1;
    check("midrst_hi", hi_gate, 0);
    check("midrst_lo", lo_gate, 0);
    check("midrst_ps", period_start, 0);
    check("midrst_busy", busy, 0);
    check("midrst_ready", cfg_ready, 1);
    emu_rst_n = 1'b1;
    repeat (2) @(posedge emu_clk);
    #1 enable = 1'b1;
    wait_ps(1);
    @(posedge emu_clk);
    push_win(2, 2, 0, 2);
    wait_ps(2);
    enable = 1'b0;
    wait_idle();

    // dead time 2: each side on 3 of its 5 raw cycles
    send_cfg(10, 5, 2);
    repeat (2) @(posedge emu_clk);
    #1 enable = 1'b1;
    wait_ps(1);
    @(posedge emu_clk);
    push_win(2, 10, 3, 3);
    wait_ps(2);
    enable = 1'b0;
    wait_idle();

    // dead time 3, shutdown while high side is on, enable pulse in SHUT ignored
    send_cfg(10, 5, 3);
    repeat (2) @(posedge emu_clk);
    #1 enable = 1'b1;
    wait_ps(2);
    @(posedge emu_clk);
    push_win(1, 10, 2, 2);
    wait_ps(1);
    repeat (4) @(posedge emu_clk);
    #1;
    check("hi_before_shut", hi_gate, 1);
    enable = 1'b0;
    @(posedge emu_clk);
    #1;
    check("shut_hi", hi_gate, 0);
    check("shut_lo", lo_gate, 0);
    check("shut_busy_1", busy, 1);
    enable = 1'b1;
    @(posedge emu_clk);
    #1;
    check("shut_busy_2", busy, 1);
    enable = 1'b0;
    @(posedge emu_clk);
    #1;
    check("shut_busy_3", busy, 1);
    @(posedge emu_clk);
    #1;
    check("shut_done_idle", busy, 0);
    repeat (3) @(posedge emu_clk);
    #1;
    check("idle_stays", busy, 0);
    check("idle_hi", hi_gate, 0);
    check("idle_lo", lo_gate, 0);

    // period below minimum and duty above period are clamped to {2,2}
    send_cfg(1, 4, 0);
    repeat (2) @(posedge emu_clk);
    #1 enable = 1'b1;
    wait_ps(2);
    @(posedge emu_clk);
    push_win(2, 2, 2, 0);
    wait_ps(2);
    check("clamp_hi", hi_gate, 1);
    check("clamp_lo", lo_gate, 0);
    enable = 1'b0;
    wait_idle();

    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
